// File: rtl/numbotron_digit_sequencer.sv
// numbotron_digit_sequencer
//   Owns the bank of display digit registers and arbitrates between two
//   writers: one-hot per-digit increment strobes from the edit UI (local,
//   no carry) and a prescaled auto-count tick that increments digit 0 and
//   ripples carries upward one digit per clock through a two-state FSM.
//
//   Optional feature: define NUMBOTRON_HEX_DIGITS_EN to make every digit
//   count modulo 16 (wrap/carry on 15->0) instead of BCD modulo 10.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset_n    synchronous active-low reset
//   run        enables auto-count on slow_tick
//   clear      synchronous clear of digits, overflow and any pending tick
//   edit_inc   one-hot increment request, bit k targets digit k
//   slow_tick  one-clk strobe every PRESCALE clks (registered)
//   digits     digit k on bits [4k+3:4k] (registered)
//   busy       high while a carry ripple is in progress (registered)
//   overflow   sticky, set when the top digit wraps during auto-count
//   edit_drop  one-clk pulse when an edit request is rejected
module numbotron_digit_sequencer #(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 50000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
    input  logic                    clear,
    input  logic [NUM_DIGITS-1:0]   edit_inc,
    output logic                    slow_tick,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    busy,
    output logic                    overflow,
    output logic                    edit_drop
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

`ifdef NUMBOTRON_HEX_DIGITS_EN
    localparam logic [3:0] DIGIT_MAX = 4'd15;
`else
    localparam logic [3:0] DIGIT_MAX = 4'd9;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        RIPPLE = 1'b1
    } state_t;

    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d == DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    logic [PW-1:0]           presc_reg, presc_next;
    logic                    slow_tick_reg;
    logic                    tick_pending_reg, tick_pending_next;
    state_t                  state_reg, state_next;
    logic [IW-1:0]           idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
    logic                    busy_reg;
    logic                    overflow_reg, overflow_next;
    logic                    edit_drop_reg, edit_drop_next;

    logic       edit_any;
    logic       edit_onehot;
    logic       edit_apply;
    logic       tick_apply;
    logic       ripple_apply;
    logic       clear_all;
    logic [3:0] ripple_digit;

    assign edit_any     = |edit_inc;
    assign edit_onehot  = $onehot(edit_inc);
    assign ripple_digit = digits_reg[{idx_reg, 2'b00} +: 4];

    // Free-running prescaler; the strobe is registered so it appears the
    // cycle after the count sits at its last value.
    assign presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);

    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        overflow_next     = overflow_reg;
        // A new tick only latches when run is high; a tick arriving while
        // one is already pending merges into it and is effectively lost.
        tick_pending_next = tick_pending_reg | (slow_tick_reg & run);
        edit_apply        = 1'b0;
        tick_apply        = 1'b0;
        ripple_apply      = 1'b0;
        clear_all         = 1'b0;

        if (clear) begin
            clear_all         = 1'b1;
            state_next        = IDLE;
            idx_next          = '0;
            overflow_next     = 1'b0;
            tick_pending_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (edit_onehot) begin
                        // Edit wins; the pending tick simply waits.
                        edit_apply = 1'b1;
                    end else if (tick_pending_reg) begin
                        tick_apply        = 1'b1;
                        tick_pending_next = slow_tick_reg & run;
                        if (digits_reg[3:0] == DIGIT_MAX) begin
                            idx_next   = IW'(1);
                            state_next = RIPPLE;
                        end
                    end
                end
                RIPPLE: begin
                    ripple_apply = 1'b1;
                    if (ripple_digit == DIGIT_MAX) begin
                        if (idx_reg == LAST_IDX) begin
                            overflow_next = 1'b1;
                            state_next    = IDLE;
                            idx_next      = '0;
                        end else begin
                            idx_next = idx_reg + IW'(1);
                        end
                    end else begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end

        // Any nonzero request that did not land is reported: multi-hot,
        // arriving mid-ripple, or superseded by clear.
        edit_drop_next = edit_any & ~edit_apply;
    end

    // Per-digit increment enables and next values.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic       inc_en;
        logic [3:0] cur;

        assign cur    = digits_reg[4*gi +: 4];
        assign inc_en = (edit_apply & edit_inc[gi])
                      | (tick_apply & (gi == 0))
                      | (ripple_apply & (idx_reg == IW'(gi)));
        assign digits_next[4*gi +: 4] = clear_all ? 4'd0
                                      : (inc_en ? digit_inc(cur) : cur);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_reg        <= '0;
            slow_tick_reg    <= 1'b0;
            tick_pending_reg <= 1'b0;
            state_reg        <= IDLE;
            idx_reg          <= '0;
            digits_reg       <= '0;
            busy_reg         <= 1'b0;
            overflow_reg     <= 1'b0;
            edit_drop_reg    <= 1'b0;
        end else begin
            presc_reg        <= presc_next;
            slow_tick_reg    <= (presc_reg == PRESC_LAST);
            tick_pending_reg <= tick_pending_next;
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            digits_reg       <= digits_next;
            busy_reg         <= (state_next == RIPPLE);
            overflow_reg     <= overflow_next;
            edit_drop_reg    <= edit_drop_next;
        end
    end

    assign slow_tick = slow_tick_reg;
    assign digits    = digits_reg;
    assign busy      = busy_reg;
    assign overflow  = overflow_reg;
    assign edit_drop = edit_drop_reg;

endmodule

// File: doc/numbotron_digit_sequencer.md
Name: numbotron_digit_sequencer

Overview:
- Owns the bank of BCD digit registers behind the numbotron display and decides who may change them.
- Two sources share the bank:
  - one-hot per-digit increment strobes from the digit-edit UI;
  - an internal auto-count tick.
- Generates the slow tick strobe from a prescaler.
- Edits are local (no carry). Auto-count increments digit 0 and ripples carries one digit per clock through a small FSM.

Parameters:
- NUM_DIGITS, 8, number of 4-bit digits in the bank (2..32).
- PRESCALE, 50000, clk cycles per slow_tick strobe (>= 2).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- run  in  1  enables auto-count on slow_tick.
- clear  in  1  synchronous clear of digits and overflow.
- edit_inc  in  NUM_DIGITS  one-hot increment request; bit k targets digit k; valid for one clk.
- slow_tick  out  1  one-clk strobe every PRESCALE clks.
- digits  out  4*NUM_DIGITS  digit k on bits [4k+3:4k].
- busy  out  1  high while a carry ripple is in progress.
- overflow  out  1  sticky; set when the top digit wraps during auto-count.
- edit_drop  out  1  one-clk pulse when an edit request is rejected.

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0; prescaler=0; FSM=IDLE; tick_pending=0; carry index=0. Reset mid-ripple aborts the ripple.
- All outputs are registered.
- Prescaler counts 0..PRESCALE-1 and then wraps. slow_tick=1 for the cycle after the count reaches PRESCALE-1. The prescaler free-runs and is independent of run, clear and FSM state.
- tick_pending is set by slow_tick when run=1. It holds one tick only; a further tick while pending is lost.
- FSM states: IDLE, RIPPLE. Per-cycle priority in IDLE: clear > edit > pending tick.
  - clear (any state): all digits=0, overflow=0, tick_pending=0, FSM->IDLE, busy=0.
  - Edit, IDLE, edit_inc exactly one-hot, bit k: digit k = (digit k + 1) mod 10 on the next edge. No carry. overflow unaffected. Any pending tick waits.
  - Edit, any state, edit_inc has more than one bit set: ignored; edit_drop=1 next cycle.
  - Edit, RIPPLE, edit_inc nonzero: ignored; edit_drop=1 next cycle.
  - Pending tick, IDLE, no edit or clear this cycle: digit 0 increments and tick_pending is cleared.
    - digit 0 was 9: it becomes 0, carry index=1, FSM->RIPPLE.
    - Otherwise the FSM stays in IDLE.
  - RIPPLE, each clk: digit[idx] increments.
    - If it wraps 9->0 and idx<NUM_DIGITS-1: idx++ and stay in RIPPLE.
    - If it wraps and idx=NUM_DIGITS-1: overflow=1, FSM->IDLE.
    - If no wrap: FSM->IDLE.
- busy = (FSM==RIPPLE), registered.
- Latency:
  - An edit sampled at edge N is visible after edge N.
  - A tick serviced at edge N updates digit 0 after edge N and digit k after edge N+k.
- Digit values are always 0..9, or 0..15 when the optional feature is enabled.

Optional Feature:
- Macro NUMBOTRON_HEX_DIGITS_EN.
- When defined: digits count modulo 16. Wrap and carry occur on 15->0 for both edit and auto-count.
- When undefined: BCD, modulo 10 as described above.

Test Plan:
- Reset: hold reset_n=0 for 3 clks with run=1 and edit_inc=all-ones. Required: digits=0, busy=0, overflow=0, slow_tick=0, edit_drop=0 throughout and on the first cycle after release.
- Edit: from zero, edit_inc=8'h04 for 1 clk. Required: digit2=1 and all others 0 next cycle. Then set digit0=9 and pulse edit_inc=8'h01. Required: digit0=0, digit1 unchanged, busy stays 0.
- Ripple: preload digits 2..0=9, run=1, PRESCALE=4, wait for tick. Required after service edge N: digit0=0 at N+1, digit1=0 at N+2, digit2=0 at N+3, digit3=1 at N+4; busy=1 for exactly 3 cycles.
- Overflow: all 8 digits=9, tick. Required: all digits 0 after NUM_DIGITS edges and overflow=1 sticky. Then clear=1 for 1 clk. Required: overflow=0.
- Arbitration: edit_inc=8'h01 in the same cycle as the tick service. Required: edit applied first, tick applied the following cycle (digit0 +2 total). edit_inc=8'h02 during busy. Required: edit_drop pulse, digit1 unchanged.
- Multi-hot edit: edit_inc=8'h03 in IDLE. Required: no digit change, edit_drop=1 for one cycle. Build with NUMBOTRON_HEX_DIGITS_EN. Required: digit0 edit walks 9->10->...->15->0.
